// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl -- pipeline hazard and memory-wait stall controller.
//
// Purpose:
//   Combinationally produces stall/flush/bubble controls for a 5-stage RV32
//   pipeline from three hazard sources: a data-memory wait (freeze), a taken
//   branch/jump resolved in EX (flush), and a load-use dependency between EX
//   and ID (one-cycle stall). It also keeps saturating stall/flush event
//   counters and a sticky memory-timeout flag.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   inst_ID, inst_EX              instructions in decode / execute
//   RegWEn_EX, WBSel_EX           EX writes the register file / writeback source
//   PCSel_EX                      branch or jump taken in EX
//   dmem_req_MEM, dmem_ready      data-memory access in MEM / access completes
//   stall_PC .. stall_EX_MEM      hold the corresponding register
//   flush_IF_ID, flush_ID_EX      load a NOP into the register
//   bubble_MEM_WB                 load a bubble into MEM/WB
//   mem_timeout                   sticky: memory wait reached TIMEOUT cycles
//   stall_cnt, flush_cnt          saturating event counters

package rv32_pkg;
    typedef enum logic [1:0] {
        WB_PC  = 2'd0,
        WB_ALU = 2'd1,
        WB_MEM = 2'd2,
        WB_IMM = 2'd3
    } WBSel_t;
endpackage

// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | no memory access outstanding; pipeline advances normally
// MEM_WAIT | a data access is waiting on dmem_ready; pipeline frozen
module hazard_stall_ctrl
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_ID,
    input  logic [31:0]      inst_EX,
    input  logic             RegWEn_EX,
    input  WBSel_t           WBSel_EX,
    input  logic             PCSel_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             stall_PC,
    output logic             stall_IF_ID,
    output logic             stall_ID_EX,
    output logic             stall_EX_MEM,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             bubble_MEM_WB,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int unsigned WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    logic [6:0] opcode_ID;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic [4:0] rd_EX;
    logic       rs1_used;
    logic       rs2_used;
    logic       load_use;
    logic       freeze;

    // Instruction fields that play no part in hazard detection.
    logic unused_bits;
    assign unused_bits = ^{inst_ID[31:25], inst_ID[14:7], inst_EX[31:12], inst_EX[6:0]};

    assign opcode_ID = inst_ID[6:0];
    assign rs1_ID    = inst_ID[19:15];
    assign rs2_ID    = inst_ID[24:20];
    assign rd_EX     = inst_EX[11:7];

    // Only formats that really read a source register may cause a stall;
    // otherwise immediate bits that happen to alias rd_EX would stall falsely.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode_ID)
            7'b0110011,
            7'b0100011,
            7'b1100011: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            7'b0010011,
            7'b0000011,
            7'b1100111: rs1_used = 1'b1;
            default: ;
        endcase
    end

    assign load_use = RegWEn_EX && (WBSel_EX == WB_MEM) && (rd_EX != 5'd0) &&
                      ((rs1_used && (rs1_ID == rd_EX)) || (rs2_used && (rs2_ID == rd_EX)));

    // The cycle dmem_ready arrives the access completes, so the pipeline
    // advances on that cycle rather than staying frozen for one more.
    assign freeze = !dmem_ready && ((state == MEM_WAIT) || dmem_req_MEM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        stall_PC      = 1'b0;
        stall_IF_ID   = 1'b0;
        stall_ID_EX   = 1'b0;
        stall_EX_MEM  = 1'b0;
        flush_IF_ID   = 1'b0;
        flush_ID_EX   = 1'b0;
        bubble_MEM_WB = 1'b0;

        case (state)
            RUN:      if (dmem_req_MEM && !dmem_ready) state_nxt = MEM_WAIT;
            MEM_WAIT: if (dmem_ready) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase

        // A branch seen while frozen needs no memory: EX is held, so
        // PCSel_EX is presented again on the first unfrozen cycle.
        if (freeze) begin
            stall_PC      = 1'b1;
            stall_IF_ID   = 1'b1;
            stall_ID_EX   = 1'b1;
            stall_EX_MEM  = 1'b1;
            bubble_MEM_WB = 1'b1;
        end else if (PCSel_EX) begin
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (load_use) begin
            stall_PC    = 1'b1;
            stall_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end
    end

    always_comb begin
        wait_nxt = wait_cnt;
        if (state == MEM_WAIT) begin
            if (dmem_ready) begin
                wait_nxt = '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_nxt = wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if ((state == MEM_WAIT) && !dmem_ready && (wait_nxt == WAIT_MAX)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_PC && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_IF_ID && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule
